// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI byte transmitter: state encoding, timing
// defaults and panel command bytes.
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StSetup,
    StShift,
    StDesel
  } state_e;

  // Defaults assume a 50 MHz clock: 6.25 MHz SCLK, 10 ms reset pulse and wait.
  localparam int unsigned ClkDivDefault   = 4;
  localparam int unsigned RstPulseDefault = 500000;
  localparam int unsigned RstWaitDefault  = 500000;

  // Panel command bytes; page/column commands carry their argument in the low bits.
  localparam logic [7:0] CmdDisplayOff = 8'hAE;
  localparam logic [7:0] CmdDisplayOn  = 8'hAF;
  localparam logic [7:0] CmdPageSet    = 8'hB0;
  localparam logic [7:0] CmdColSetHi   = 8'h10;
  localparam logic [7:0] CmdColSetLo   = 8'h00;
  localparam logic [7:0] CmdStartLine  = 8'h40;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_por_seq.sv
// Panel power-up sequencer: holds lcd_rst_n low, then waits before declaring the
// panel ready. done_pulse marks the cycle whose clock edge raises init_done.
module lcd_por_seq
  import lcd_spi_pkg::*;
#(
  parameter int unsigned RST_PULSE = RstPulseDefault,
  parameter int unsigned RST_WAIT  = RstWaitDefault
) (
  input  logic clk,
  input  logic rst,
  output logic lcd_rst_n,
  output logic init_done,
  output logic done_pulse
);

  localparam int unsigned SeqMax = max_u(RST_PULSE, RST_WAIT);
  localparam int unsigned SeqW   = $clog2(SeqMax + 1);
  localparam logic [SeqW-1:0] PulseLast = SeqW'(RST_PULSE - 1);
  localparam logic [SeqW-1:0] WaitLast  = SeqW'(RST_WAIT - 1);

  state_e          state_q, state_d;
  logic [SeqW-1:0] cnt_q, cnt_d;
  logic            rst_n_q, rst_n_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRstLow;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_n_d    = rst_n_q;
    done_d     = done_q;
    done_pulse = 1'b0;
    unique case (state_q)
      StRstLow: begin
        if (cnt_q == PulseLast) begin
          state_d = StRstWait;
          cnt_d   = '0;
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRstWait: begin
        if (cnt_q == WaitLast) begin
          state_d    = StIdle;
          cnt_d      = '0;
          done_d     = 1'b1;
          done_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign lcd_rst_n = rst_n_q;
  assign init_done = done_q;

endmodule

// File: rtl/lcd_spi_tx.sv
// LCD byte transmitter: runs the panel power-up sequence, then serializes
// command/data bytes as SPI mode 0, MSB first, with A0 held for the frame.
module lcd_spi_tx
  import lcd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = ClkDivDefault,
  parameter int unsigned RST_PULSE = RstPulseDefault,
  parameter int unsigned RST_WAIT  = RstWaitDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       tx_ready,
  output logic       init_done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       lcd_a0,
  output logic       lcd_rst_n
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            a0_q, a0_d;
  logic            ready_q, ready_d;
  logic            por_done;
  logic            div_last;

  lcd_por_seq #(
    .RST_PULSE (RST_PULSE),
    .RST_WAIT  (RST_WAIT)
  ) u_por_seq (
    .clk        (clk),
    .rst        (rst),
    .lcd_rst_n  (lcd_rst_n),
    .init_done  (init_done),
    .done_pulse (por_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRstLow;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      a0_q    <= a0_d;
      ready_q <= ready_d;
    end
  end

  assign div_last = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    a0_d    = a0_q;
    ready_d = ready_q;
    unique case (state_q)
      // The sequencer owns the power-up phases; ready rises on the same edge as init_done.
      StRstLow, StRstWait: begin
        if (por_done) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end
      end
      StIdle: begin
        if (tx_valid && ready_q && init_done) begin
          state_d = StSetup;
          shreg_d = tx_data;
          a0_d    = tx_dc;
          mosi_d  = tx_data[7];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (div_last) begin
          state_d = StShift;
          div_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_last) begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit, except after the last one.
            sclk_d = 1'b0;
            if (bit_q != 3'd7) begin
              shreg_d = {shreg_q[6:0], 1'b0};
              mosi_d  = shreg_q[6];
            end
          end else if (bit_q == 3'd7) begin
            state_d = StDesel;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDesel: begin
        if (div_last) begin
          state_d = StIdle;
          div_d   = '0;
          ready_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StRstLow;
    endcase
  end

  assign tx_ready = ready_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign lcd_a0   = a0_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: power-up timing, byte framing, back-to-back
// transfers, early offers, mid-byte reset and the fastest SCLK divider.
module tb_lcd_spi_tx;

  logic       clk = 1'b0;
  logic       rst, rst1;
  logic       tx_valid, tx_dc, tx_valid1, tx_dc1;
  logic [7:0] tx_data, tx_data1;
  logic       tx_ready, init_done, spi_sclk, spi_mosi, spi_cs_n, lcd_a0, lcd_rst_n;
  logic       tx_ready1, init_done1, sclk1, mosi1, cs_n1, a01, lcd_rst_n1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lcd_spi_tx #(.CLK_DIV(2), .RST_PULSE(10), .RST_WAIT(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_dc     (tx_dc),
    .tx_ready  (tx_ready),
    .init_done (init_done),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .lcd_a0    (lcd_a0),
    .lcd_rst_n (lcd_rst_n)
  );

  lcd_spi_tx #(.CLK_DIV(1), .RST_PULSE(10), .RST_WAIT(5)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .tx_valid  (tx_valid1),
    .tx_data   (tx_data1),
    .tx_dc     (tx_dc1),
    .tx_ready  (tx_ready1),
    .init_done (init_done1),
    .spi_sclk  (sclk1),
    .spi_mosi  (mosi1),
    .spi_cs_n  (cs_n1),
    .lcd_a0    (a01),
    .lcd_rst_n (lcd_rst_n1)
  );

  // SPI receiver model sampling the pins between clock edges.
  logic       sclk_p = 1'b0, cs_p = 1'b1, a0_p = 1'b0;
  logic [7:0] rx_sh = '0, last_rx = '0;
  int         rx_cnt = 0, last_cnt = 0, sclk_rises = 0, a0_glitch = 0;
  logic       sclk1_p = 1'b0, cs1_p = 1'b1;
  logic [7:0] rx1_sh = '0, last_rx1 = '0;
  int         rx1_cnt = 0, last_cnt1 = 0;

  always @(negedge clk) begin
    sclk_p <= spi_sclk;
    cs_p   <= spi_cs_n;
    a0_p   <= lcd_a0;
    if (spi_sclk === 1'b1 && sclk_p === 1'b0) sclk_rises <= sclk_rises + 1;
    if (spi_cs_n === 1'b0 && cs_p === 1'b1) begin
      rx_cnt <= 0;
      rx_sh  <= '0;
    end else if (spi_cs_n === 1'b0 && spi_sclk === 1'b1 && sclk_p === 1'b0) begin
      rx_sh  <= {rx_sh[6:0], spi_mosi};
      rx_cnt <= rx_cnt + 1;
    end
    if (spi_cs_n === 1'b1 && cs_p === 1'b0) begin
      last_rx  <= rx_sh;
      last_cnt <= rx_cnt;
    end
    if (spi_cs_n === 1'b0 && cs_p === 1'b0 && lcd_a0 !== a0_p) a0_glitch <= a0_glitch + 1;

    sclk1_p <= sclk1;
    cs1_p   <= cs_n1;
    if (cs_n1 === 1'b0 && cs1_p === 1'b1) begin
      rx1_cnt <= 0;
      rx1_sh  <= '0;
    end else if (cs_n1 === 1'b0 && sclk1 === 1'b1 && sclk1_p === 1'b0) begin
      rx1_sh  <= {rx1_sh[6:0], mosi1};
      rx1_cnt <= rx1_cnt + 1;
    end
    if (cs_n1 === 1'b1 && cs1_p === 1'b0) begin
      last_rx1  <= rx1_sh;
      last_cnt1 <= rx1_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_idle;
    int snap;
    int n;
    rst = 1'b1;  rst1 = 1'b1;
    tx_valid = 1'b0;  tx_data = '0;  tx_dc = 1'b0;
    tx_valid1 = 1'b0; tx_data1 = '0; tx_dc1 = 1'b0;
    repeat (3) tick();
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_a0", lcd_a0, 0);
    check("rst_lcd_rst_n", lcd_rst_n, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_init_done", init_done, 0);

    // Power-up sequence: rst_n high after 10 edges, ready after 15.
    @(negedge clk);
    rst = 1'b0;
    rst1 = 1'b0;
    bad_idle = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) bad_idle++;
      if (k == 9)  check("por_rst_low_9", lcd_rst_n, 0);
      if (k == 10) check("por_rst_high_10", lcd_rst_n, 1);
      if (k == 14) check("por_init_done_14", init_done, 0);
      if (k == 14) check("por_ready_14", tx_ready, 0);
      if (k == 15) check("por_init_done_15", init_done, 1);
      if (k == 15) check("por_ready_15", tx_ready, 1);
    end
    check("por_pins_idle", bad_idle, 0);

    // Single byte 0xA5 as a command.
    tx_data = 8'hA5; tx_dc = 1'b0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("a5_cs_fall", spi_cs_n, 0);
    check("a5_ready_low", tx_ready, 0);
    check("a5_mosi_bit7", spi_mosi, 1);
    repeat (33) tick();
    check("a5_cs_low_33", spi_cs_n, 0);
    tick();
    check("a5_cs_rise_34", spi_cs_n, 1);
    tick();
    check("a5_ready_35", tx_ready, 0);
    tick();
    check("a5_ready_36", tx_ready, 1);
    check("a5_rx_byte", last_rx, 8'hA5);
    check("a5_rx_bits", last_cnt, 8);
    check("a5_a0", lcd_a0, 0);

    // Back-to-back with tx_valid held: 0x00 data, then 0xFF command.
    tx_data = 8'h00; tx_dc = 1'b1; tx_valid = 1'b1;
    tick();
    check("b2b_cs_fall", spi_cs_n, 0);
    check("b2b_a0_data", lcd_a0, 1);
    tx_data = 8'hFF; tx_dc = 1'b0;
    repeat (35) tick();
    check("b2b_ready_35", tx_ready, 0);
    tick();
    check("b2b_ready_36", tx_ready, 1);
    check("b2b_a0_held", lcd_a0, 1);
    check("b2b_rx_first", last_rx, 8'h00);
    tick();
    tx_valid = 1'b0;
    check("b2b_second_cs", spi_cs_n, 0);
    check("b2b_second_ready", tx_ready, 0);
    check("b2b_a0_cmd", lcd_a0, 0);
    repeat (36) tick();
    check("b2b_ready_end", tx_ready, 1);
    check("b2b_rx_second", last_rx, 8'hFF);
    check("b2b_rx_bits", last_cnt, 8);
    check("a0_stable_in_frame", a0_glitch, 0);

    // Mid-byte reset after the 4th rising edge.
    tx_data = 8'h5A; tx_dc = 1'b1; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (rx_cnt != 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_fourth_rise", rx_cnt, 4);
    rst = 1'b1;
    #1;
    check("mid_cs_n", spi_cs_n, 1);
    check("mid_sclk", spi_sclk, 0);
    check("mid_lcd_rst_n", lcd_rst_n, 0);
    check("mid_tx_ready", tx_ready, 0);
    check("mid_init_done", init_done, 0);

    // Byte 0x3C offered before the power-up sequence completes.
    tx_data = 8'h3C; tx_dc = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    snap = sclk_rises;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 9)  check("re_rst_low_9", lcd_rst_n, 0);
      if (k == 10) check("re_rst_high_10", lcd_rst_n, 1);
      if (k == 14) check("re_ready_14", tx_ready, 0);
      if (k == 15) check("re_ready_15", tx_ready, 1);
      if (k == 15) check("re_cs_idle", spi_cs_n, 1);
    end
    check("early_no_sclk", sclk_rises, snap);
    tick();
    tx_valid = 1'b0;
    check("early_accept_cs", spi_cs_n, 0);
    check("early_accept_ready", tx_ready, 0);
    check("early_a0", lcd_a0, 1);
    repeat (36) tick();
    check("early_ready_end", tx_ready, 1);
    check("early_rx_byte", last_rx, 8'h3C);
    check("early_rx_bits", last_cnt, 8);

    // Fastest divider: 0x81 with a 2-cycle SCLK period.
    check("div1_ready", tx_ready1, 1);
    tx_data1 = 8'h81; tx_dc1 = 1'b0; tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    check("div1_cs_fall", cs_n1, 0);
    check("div1_sclk_0", sclk1, 0);
    tick();
    check("div1_sclk_1", sclk1, 1);
    tick();
    check("div1_sclk_2", sclk1, 0);
    tick();
    check("div1_sclk_3", sclk1, 1);
    repeat (14) tick();
    check("div1_cs_rise_17", cs_n1, 1);
    check("div1_ready_17", tx_ready1, 0);
    tick();
    check("div1_ready_18", tx_ready1, 1);
    check("div1_rx_byte", last_rx1, 8'h81);
    check("div1_rx_bits", last_cnt1, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
